// File: rtl/proc_pkg.sv
// -----------------------------------------------------------------------------
// proc_pkg
// Shared definitions for the pipeline memory stage and its neighbours:
//   - instruction opcode constants (IR[31:27])
//   - IR field positions (opcode, rd, rs, imm)
//   - memory-stage FSM state encoding
//   - small IR decode helpers
// No ports (package).
// -----------------------------------------------------------------------------
package proc_pkg;

  // Opcode constants (IR[31:27])
  localparam logic [4:0] OPC_ALU  = 5'b00000;  // register-register ALU ops (add, sub, ...)
  localparam logic [4:0] OPC_ADDI = 5'b00101;
  localparam logic [4:0] OPC_SW   = 5'b00111;
  localparam logic [4:0] OPC_LW   = 5'b01000;
  localparam logic [4:0] OPC_J    = 5'b00100;

  // IR field positions
  localparam int OPC_HI = 31;
  localparam int OPC_LO = 27;
  localparam int RD_HI  = 26;
  localparam int RD_LO  = 22;
  localparam int RS_HI  = 21;
  localparam int RS_LO  = 17;
  localparam int IMM_HI = 16;
  localparam int IMM_LO = 0;

  // All-zero IR decodes as an ALU op writing r0, i.e. a no-op.
  localparam logic [31:0] NOP_IR = 32'h0000_0000;

  // Memory-stage FSM encoding
  typedef enum logic {
    IDLE = 1'b0,
    WAIT = 1'b1
  } mem_state_e;

  // Extract the opcode field from an instruction word.
  function automatic logic [4:0] ir_opcode(input logic [31:0] ir);
    return ir[OPC_HI:OPC_LO];
  endfunction

  // Extract the destination register field from an instruction word.
  function automatic logic [4:0] ir_rd(input logic [31:0] ir);
    return ir[RD_HI:RD_LO];
  endfunction

endpackage

// File: rtl/mw_out_reg.sv
// -----------------------------------------------------------------------------
// mw_out_reg
// M/W-side output register bank of the memory stage.
// Controls (priority load > clear > bubble > hold):
//   load   : capture ld_ir/ld_o/ld_d and mark the slot valid
//   clear  : no instruction arriving; IR becomes a nop, slot invalid,
//            O and D hold their last values
//   bubble : slot invalid, all data fields hold
// Ports:
//   clk, reset (async, active-low)
//   load, clear, bubble          control strobes
//   ld_ir, ld_o, ld_d [31:0]     data to capture on load
//   ir, o, d [31:0], valid       registered M/W latch inputs
// -----------------------------------------------------------------------------
module mw_out_reg
  import proc_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        load,
  input  logic        clear,
  input  logic        bubble,
  input  logic [31:0] ld_ir,
  input  logic [31:0] ld_o,
  input  logic [31:0] ld_d,
  output logic [31:0] ir,
  output logic [31:0] o,
  output logic [31:0] d,
  output logic        valid
);

  // M/W register bank update.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ir    <= NOP_IR;
      o     <= 32'h0000_0000;
      d     <= 32'h0000_0000;
      valid <= 1'b0;
    end else if (load) begin
      ir    <= ld_ir;
      o     <= ld_o;
      d     <= ld_d;
      valid <= 1'b1;
    end else if (clear) begin
      ir    <= NOP_IR;
      valid <= 1'b0;
    end else if (bubble) begin
      valid <= 1'b0;
    end
  end

endmodule

// File: rtl/mem_stage.sv
// -----------------------------------------------------------------------------
// mem_stage
// Consumer end of the X/M pipeline latch. Executes lw/sw against a
// variable-latency data memory over a req/ack handshake, stalls the front of
// the pipeline while an access is outstanding, and drives the registered
// inputs of the M/W latch.
//
// Optional build macro: MEM_STAGE_TIMEOUT_EN
//   defined   : a WAIT-state counter aborts an access after TIMEOUT_CYCLES
//               cycles without ack; mem_err is set and stays set until reset.
//   undefined : WAIT persists until ack; mem_err is tied to 0.
//
// Ports:
//   clk                 rising-edge clock
//   reset               asynchronous, active-low reset
//   xm_IR/xm_O/xm_B     instruction, ALU result/address, store data from X/M
//   xm_valid            X/M holds a live instruction
//   stall               combinational: hold PC, F/D, D/X and X/M this cycle
//   mem_req/mem_we      registered request and write-enable
//   mem_addr            registered word address (xm_O[ADDR_W-1:0])
//   mem_wdata           registered store data
//   mem_ack/mem_rdata   one-cycle completion pulse and read data
//   mw_IR/mw_O/mw_D     registered M/W latch inputs (mw_D = 0 for non-loads)
//   mw_valid            mw_* hold a live instruction
//   mem_err             timeout flag, sticky until reset
// -----------------------------------------------------------------------------
module mem_stage
  import proc_pkg::*;
#(
  parameter int         ADDR_W         = 12,
  parameter logic [4:0] OP_LW          = OPC_LW,
  parameter logic [4:0] OP_SW          = OPC_SW,
  parameter int         TIMEOUT_CYCLES = 16
)
(
  input  logic              clk,
  input  logic              reset,
  input  logic [31:0]       xm_IR,
  input  logic [31:0]       xm_O,
  input  logic [31:0]       xm_B,
  input  logic              xm_valid,
  output logic              stall,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  input  logic              mem_ack,
  input  logic [31:0]       mem_rdata,
  output logic [31:0]       mw_IR,
  output logic [31:0]       mw_O,
  output logic [31:0]       mw_D,
  output logic              mw_valid,
  output logic              mem_err
);

  mem_state_e  state_r;
  logic [4:0]  opcode_s;
  logic        is_ld_s;
  logic        is_st_s;
  logic        is_mem_s;
  logic        ack_hit_s;
  logic        timeout_s;
  logic        done_s;
  logic        mw_load_s;
  logic        mw_clear_s;
  logic        mw_bubble_s;
  logic [31:0] mw_d_s;

  assign opcode_s  = ir_opcode(xm_IR);
  assign is_ld_s   = (opcode_s == OP_LW);
  assign is_st_s   = (opcode_s == OP_SW);
  assign is_mem_s  = xm_valid & (is_ld_s | is_st_s);

  // An ack only counts while a request is outstanding; in IDLE it is ignored.
  assign ack_hit_s = (state_r == WAIT) & mem_ack;
  assign done_s    = ack_hit_s | timeout_s;

  // Release the pipeline in the very cycle the access completes (or aborts),
  // so X/M advances on the same edge that retires the memory op.
  assign stall     = is_mem_s & ~done_s;

`ifdef MEM_STAGE_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [CNT_W-1:0] wait_cnt_r;
  logic             mem_err_r;

  // The counter holds the number of WAIT cycles already spent without ack;
  // the abort fires in the TIMEOUT_CYCLES-th WAIT cycle.
  assign timeout_s = (state_r == WAIT) & ~mem_ack &
                     (wait_cnt_r == CNT_W'(TIMEOUT_CYCLES - 1));
  assign mem_err   = mem_err_r;

  // Ack watchdog counter and sticky timeout flag.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wait_cnt_r <= {CNT_W{1'b0}};
      mem_err_r  <= 1'b0;
    end else begin
      if ((state_r == WAIT) && !done_s) begin
        wait_cnt_r <= wait_cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
      end else begin
        wait_cnt_r <= {CNT_W{1'b0}};
      end
      if (timeout_s) begin
        mem_err_r <= 1'b1;
      end
    end
  end
`else
  assign timeout_s = 1'b0;
  assign mem_err   = 1'b0;
`endif

  // Select the M/W register bank action for this cycle.
  always_comb begin
    mw_load_s   = 1'b0;
    mw_clear_s  = 1'b0;
    mw_bubble_s = 1'b0;
    case (state_r)
      IDLE: begin
        if (is_mem_s) begin
          mw_bubble_s = 1'b1;        // issue cycle: nothing retires
        end else if (xm_valid) begin
          mw_load_s   = 1'b1;        // non-memory op passes straight through
        end else begin
          mw_clear_s  = 1'b1;
        end
      end
      WAIT: begin
        if (done_s) begin
          mw_load_s   = 1'b1;
        end else begin
          mw_bubble_s = 1'b1;
        end
      end
      default: begin
        mw_clear_s = 1'b1;
      end
    endcase
  end

  // Loaded data: only a load that completed with ack returns memory data.
  // The request's own we flag identifies the op, so a store or an aborted
  // load retires with D = 0.
  always_comb begin
    if (ack_hit_s && !mem_we) begin
      mw_d_s = mem_rdata;
    end else begin
      mw_d_s = 32'h0000_0000;
    end
  end

  // Request FSM: issue from IDLE, hold the request stable in WAIT, drop it on
  // ack or abort. There is no back-to-back issue from WAIT.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r   <= IDLE;
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= {ADDR_W{1'b0}};
      mem_wdata <= 32'h0000_0000;
    end else begin
      case (state_r)
        IDLE: begin
          if (is_mem_s) begin
            mem_req   <= 1'b1;
            mem_we    <= is_st_s;
            mem_addr  <= xm_O[ADDR_W-1:0];
            mem_wdata <= xm_B;
            state_r   <= WAIT;
          end
        end
        WAIT: begin
          if (done_s) begin
            mem_req <= 1'b0;
            state_r <= IDLE;
          end
        end
        default: begin
          mem_req <= 1'b0;
          state_r <= IDLE;
        end
      endcase
    end
  end

  mw_out_reg u_mw_out_reg (
    .clk    (clk),
    .reset  (reset),
    .load   (mw_load_s),
    .clear  (mw_clear_s),
    .bubble (mw_bubble_s),
    .ld_ir  (xm_IR),
    .ld_o   (xm_O),
    .ld_d   (mw_d_s),
    .ir     (mw_IR),
    .o      (mw_O),
    .d      (mw_D),
    .valid  (mw_valid)
  );

endmodule

// File: tb/tb_mem_stage.sv
// -----------------------------------------------------------------------------
// tb_mem_stage
// Self-checking bench for mem_stage. Every retiring instruction's expected
// {IR, O, D} is queued when it is driven; a negedge monitor pops and compares
// whenever mw_valid is high. Scenario tasks add their own inline checks.
// Build with +define+MEM_STAGE_TIMEOUT_EN to exercise the abort path
// (TIMEOUT_CYCLES = 4 here).
// -----------------------------------------------------------------------------
module tb_mem_stage;

  localparam int         ADDR_W = 12;
  localparam logic [4:0] LW_OP  = 5'b01000;
  localparam logic [4:0] SW_OP  = 5'b00111;

  logic              clk = 1'b0;
  logic              reset;
  logic [31:0]       xm_IR, xm_O, xm_B;
  logic              xm_valid;
  logic              stall;
  logic              mem_req, mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_wdata;
  logic              mem_ack;
  logic [31:0]       mem_rdata;
  logic [31:0]       mw_IR, mw_O, mw_D;
  logic              mw_valid;
  logic              mem_err;

  typedef struct packed {
    logic [31:0] ir;
    logic [31:0] o;
    logic [31:0] d;
  } ret_t;

  ret_t exp_q[$];
  int   n_cmp = 0;
  int   n_err = 0;

  always #5 clk = ~clk;

  mem_stage #(
    .ADDR_W         (ADDR_W),
    .OP_LW          (LW_OP),
    .OP_SW          (SW_OP),
    .TIMEOUT_CYCLES (4)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .xm_IR     (xm_IR),
    .xm_O      (xm_O),
    .xm_B      (xm_B),
    .xm_valid  (xm_valid),
    .stall     (stall),
    .mem_req   (mem_req),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_ack   (mem_ack),
    .mem_rdata (mem_rdata),
    .mw_IR     (mw_IR),
    .mw_O      (mw_O),
    .mw_D      (mw_D),
    .mw_valid  (mw_valid),
    .mem_err   (mem_err)
  );

  // Scoreboard monitor: every cycle with mw_valid high retires one instruction.
  always @(negedge clk) begin
    if (reset === 1'b1 && mw_valid === 1'b1) begin
      n_cmp++;
      if (exp_q.size() == 0) begin
        n_err++;
        $display("FAIL retire_unexpected: got IR=%h O=%h D=%h, required no retirement", mw_IR, mw_O, mw_D);
      end else begin
        if ({mw_IR, mw_O, mw_D} !== exp_q[0]) begin
          n_err++;
          $display("FAIL retire: got IR=%h O=%h D=%h, required IR=%h O=%h D=%h",
                   mw_IR, mw_O, mw_D, exp_q[0].ir, exp_q[0].o, exp_q[0].d);
        end
        void'(exp_q.pop_front());
      end
    end
  end

  // Hard time limit so the run always ends.
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Drive one memory op and run it to completion. waits = WAIT cycles before
  // the ack cycle (a large value means no ack). Reports stall cycles seen.
  task automatic do_mem(input logic [31:0] ir, input logic [31:0] o, input logic [31:0] b,
                        input int waits, input logic [31:0] rdata, input logic [31:0] exp_d,
                        output int stalls);
    logic [4:0]        opc;
    logic [ADDR_W-1:0] ea;
    bit                s;
    bit                done;
    opc = ir[31:27];
    ea  = o[ADDR_W-1:0];
    xm_IR = ir; xm_O = o; xm_B = b; xm_valid = 1'b1; mem_ack = 1'b0;
    exp_q.push_back({ir, o, exp_d});
    stalls = 0;
    done   = 1'b0;
    for (int k = 0; k < 100 && !done; k++) begin
      if (k == waits + 1) begin
        mem_ack = 1'b1;
        mem_rdata = rdata;
      end
      #1;
      s = stall;
      if (s) stalls++;
      if (k == 0) begin
        n_cmp++;
        if (mem_req !== 1'b0) begin
          n_err++; $display("FAIL issue_req_idle: got %b, required 0", mem_req);
        end
      end else begin
        n_cmp++;
        if ({mem_req, mem_we, mem_addr, mem_wdata, mw_valid} !== {1'b1, (opc == SW_OP), ea, b, 1'b0}) begin
          n_err++;
          $display("FAIL wait_req k=%0d: got req=%b we=%b addr=%h wdata=%h mw_valid=%b, required 1 %b %h %h 0",
                   k, mem_req, mem_we, mem_addr, mem_wdata, mw_valid, (opc == SW_OP), ea, b);
        end
      end
      tick;
      mem_ack = 1'b0;
      if (!s) done = 1'b1;
    end
    n_cmp++;
    if (!done) begin
      n_err++; $display("FAIL mem_complete: got no completion in 100 cycles, required completion");
    end
    n_cmp++;
    if ({mem_req, mw_valid, mw_D} !== {1'b0, 1'b1, exp_d}) begin
      n_err++;
      $display("FAIL mem_retire: got req=%b mw_valid=%b mw_D=%h, required 0 1 %h", mem_req, mw_valid, mw_D, exp_d);
    end
  endtask

  task automatic test_reset;
    reset = 1'b0; xm_IR = 32'h0; xm_O = 32'h0; xm_B = 32'h0; xm_valid = 1'b0;
    mem_ack = 1'b0; mem_rdata = 32'h0;
    #2;
    n_cmp++;
    if ({mem_req, mem_we, mem_addr, mem_wdata, mem_err, stall} !== '0) begin
      n_err++; $display("FAIL reset_mem: got req=%b we=%b addr=%h wdata=%h err=%b stall=%b, required all 0",
                        mem_req, mem_we, mem_addr, mem_wdata, mem_err, stall);
    end
    n_cmp++;
    if ({mw_IR, mw_O, mw_D, mw_valid} !== '0) begin
      n_err++; $display("FAIL reset_mw: got IR=%h O=%h D=%h valid=%b, required all 0", mw_IR, mw_O, mw_D, mw_valid);
    end
    tick; tick;
    reset = 1'b1;
    tick;
  endtask

  task automatic test_alu;
    xm_IR = 32'h00C22000; xm_O = 32'd34; xm_B = 32'h5555_5555; xm_valid = 1'b1;
    exp_q.push_back({32'h00C22000, 32'd34, 32'h0});
    #1;
    n_cmp++;
    if (stall !== 1'b0) begin n_err++; $display("FAIL alu_stall: got %b, required 0", stall); end
    tick;
    n_cmp++;
    if ({mw_IR, mw_O, mw_D, mw_valid} !== {32'h00C22000, 32'd34, 32'h0, 1'b1}) begin
      n_err++; $display("FAIL alu_pass: got IR=%h O=%h D=%h valid=%b, required 00c22000 00000022 0 1",
                        mw_IR, mw_O, mw_D, mw_valid);
    end
    xm_valid = 1'b0;
    #1;
    n_cmp++;
    if (stall !== 1'b0) begin n_err++; $display("FAIL idle_stall: got %b, required 0", stall); end
    tick;
    n_cmp++;
    if ({mw_IR, mw_O, mw_valid} !== {32'h0, 32'd34, 1'b0}) begin
      n_err++; $display("FAIL idle_clear: got IR=%h O=%h valid=%b, required 0 00000022 0", mw_IR, mw_O, mw_valid);
    end
  endtask

  task automatic test_lw;
    int st;
    do_mem(32'h40C20004, 32'd100, 32'h0, 3, 32'hDEADBEEF, 32'hDEADBEEF, st);
    n_cmp++;
    if (st != 4) begin n_err++; $display("FAIL lw_stall_cycles: got %0d, required 4", st); end
    xm_valid = 1'b0;
    tick;
  endtask

  task automatic test_sw;
    int st;
    do_mem(32'h38C20004, 32'd8, 32'hFFFFFFFF, 1, 32'h1234_5678, 32'h0, st);
    n_cmp++;
    if (st != 2) begin n_err++; $display("FAIL sw_stall_cycles: got %0d, required 2", st); end
    xm_valid = 1'b0;
    tick;
  endtask

  task automatic test_back_to_back;
    int st;
    do_mem(32'h40C20004, 32'd44, 32'h0, 0, 32'hCAFE_0001, 32'hCAFE_0001, st);
    n_cmp++;
    if (st != 1) begin n_err++; $display("FAIL b2b_lw_stall: got %0d, required 1", st); end
    xm_IR = 32'h00C22000; xm_O = 32'd7; xm_valid = 1'b1;
    exp_q.push_back({32'h00C22000, 32'd7, 32'h0});
    #1;
    n_cmp++;
    if (stall !== 1'b0) begin n_err++; $display("FAIL b2b_add_stall: got %b, required 0", stall); end
    tick;
    n_cmp++;
    if ({mw_IR, mw_valid} !== {32'h00C22000, 1'b1}) begin
      n_err++; $display("FAIL b2b_add_pass: got IR=%h valid=%b, required 00c22000 1", mw_IR, mw_valid);
    end
    // Two loads in a row: the second issues from IDLE after the first retires.
    do_mem(32'h40C20004, 32'd5, 32'h0, 0, 32'h0000_1111, 32'h0000_1111, st);
    do_mem(32'h40C20004, 32'd6, 32'h0, 2, 32'h0000_2222, 32'h0000_2222, st);
    n_cmp++;
    if (st != 3) begin n_err++; $display("FAIL b2b_lw2_stall: got %0d, required 3", st); end
    xm_valid = 1'b0;
    tick;
  endtask

  task automatic test_addr_trunc;
    int st;
    do_mem(32'h40C20004, 32'hFFFF_F123, 32'h0, 1, 32'h0BAD_F00D, 32'h0BAD_F00D, st);
    xm_valid = 1'b0;
    tick;
  endtask

  task automatic test_ack_idle;
    xm_valid = 1'b0; mem_ack = 1'b1; mem_rdata = 32'hFFFF_0000;
    tick;
    mem_ack = 1'b0;
    n_cmp++;
    if ({mem_req, mw_valid, stall} !== 3'b000) begin
      n_err++; $display("FAIL ack_idle: got req=%b mw_valid=%b stall=%b, required 0 0 0", mem_req, mw_valid, stall);
    end
    tick;
  endtask

  task automatic test_reset_mid;
    xm_IR = 32'h40C20004; xm_O = 32'd300; xm_B = 32'h0; xm_valid = 1'b1;
    tick; tick;
    n_cmp++;
    if (mem_req !== 1'b1) begin n_err++; $display("FAIL rstmid_req_before: got %b, required 1", mem_req); end
    #2;
    reset = 1'b0;
    #1;
    n_cmp++;
    if ({mem_req, mw_valid} !== 2'b00) begin
      n_err++; $display("FAIL rstmid_async: got req=%b mw_valid=%b, required 0 0", mem_req, mw_valid);
    end
    xm_valid = 1'b0;
    tick;
    reset = 1'b1; mem_ack = 1'b1; mem_rdata = 32'h7777_7777;
    tick;
    mem_ack = 1'b0;
    n_cmp++;
    if ({mem_req, mw_valid, mw_D} !== {1'b0, 1'b0, 32'h0}) begin
      n_err++; $display("FAIL rstmid_late_ack: got req=%b mw_valid=%b D=%h, required 0 0 0", mem_req, mw_valid, mw_D);
    end
    tick;
  endtask

  task automatic test_timeout;
    int st;
`ifdef MEM_STAGE_TIMEOUT_EN
    do_mem(32'h40C20004, 32'd200, 32'h0, 1000, 32'h0, 32'h0, st);
    n_cmp++;
    if (st != 4) begin n_err++; $display("FAIL to_stall_cycles: got %0d, required 4", st); end
    n_cmp++;
    if (mem_err !== 1'b1) begin n_err++; $display("FAIL to_err_set: got %b, required 1", mem_err); end
    xm_valid = 1'b0;
    tick; tick; tick;
    n_cmp++;
    if (mem_err !== 1'b1) begin n_err++; $display("FAIL to_err_sticky: got %b, required 1", mem_err); end
    reset = 1'b0;
    #1;
    n_cmp++;
    if (mem_err !== 1'b0) begin n_err++; $display("FAIL to_err_reset: got %b, required 0", mem_err); end
    tick;
    reset = 1'b1;
    tick;
`else
    do_mem(32'h40C20004, 32'd200, 32'h0, 20, 32'hABCD_0123, 32'hABCD_0123, st);
    n_cmp++;
    if (st != 21) begin n_err++; $display("FAIL nto_stall_cycles: got %0d, required 21", st); end
    n_cmp++;
    if (mem_err !== 1'b0) begin n_err++; $display("FAIL nto_err: got %b, required 0", mem_err); end
    xm_valid = 1'b0;
    tick;
`endif
  endtask

  initial begin
    test_reset;
    test_alu;
    test_lw;
    test_sw;
    test_back_to_back;
    test_addr_trunc;
    test_ack_idle;
    test_reset_mid;
    test_timeout;
    tick; tick;
    n_cmp++;
    if (exp_q.size() != 0) begin
      n_err++; $display("FAIL scoreboard_drain: got %0d pending, required 0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/mem_stage.md
Name: mem_stage

Overview:
- Consumer end of the X/M pipeline latch.
- Takes the latched instruction (IR), ALU result (O) and store data (B), and runs lw/sw against a variable-latency data memory over a req/ack handshake.
- Stalls the front of the pipeline while an access is outstanding.
- Drives the registered inputs of the M/W latch: IR, O, memory data D and valid.

Parameters:
- ADDR_W, 12, data-memory word-address width; mem_addr = xm_O[ADDR_W-1:0]
- OP_LW, 5'b01000, load opcode (IR[31:27])
- OP_SW, 5'b00111, store opcode (IR[31:27])
- TIMEOUT_CYCLES, 16, ack wait limit; used only with MEM_STAGE_TIMEOUT_EN

Ports:
- clk  in  1  clock, rising edge
- reset  in  1  asynchronous, active-low reset
- xm_IR  in  32  instruction from X/M latch
- xm_O  in  32  ALU result / effective address
- xm_B  in  32  store data
- xm_valid  in  1  X/M latch holds a live instruction
- stall  out  1  hold PC, F/D, D/X and X/M this cycle
- mem_req  out  1  memory request, registered
- mem_we  out  1  1 = write (sw), registered
- mem_addr  out  ADDR_W  word address, registered
- mem_wdata  out  32  write data, registered
- mem_ack  in  1  one-cycle completion pulse from memory
- mem_rdata  in  32  read data, valid when mem_ack=1
- mw_IR  out  32  to M/W latch
- mw_O  out  32  to M/W latch
- mw_D  out  32  loaded data (0 for non-loads)
- mw_valid  out  1  mw_* hold a live instruction
- mem_err  out  1  timeout flag, sticky until reset

Behaviour:
- Reset (reset=0, asynchronous): state IDLE. All registered outputs clear: mem_req, mem_we, mem_addr, mem_wdata, mw_IR (nop), mw_O, mw_D, mw_valid, mem_err.
- is_mem = xm_valid & (xm_IR[31:27]==OP_LW | xm_IR[31:27]==OP_SW).
- stall is combinational: is_mem & ~(state==WAIT & mem_ack).
- Reset mid-operation: mem_req drops immediately. An ack arriving after reset is ignored.
- FSM has two states, IDLE and WAIT.
- IDLE with is_mem (issue cycle):
  - Next edge sets mem_req=1, mem_we=(opcode==OP_SW), mem_addr=xm_O[ADDR_W-1:0], mem_wdata=xm_B.
  - mw_valid<=0, which inserts a bubble.
  - Next state WAIT.
- IDLE, xm_valid and not memory op: next edge loads mw_IR=xm_IR, mw_O=xm_O, mw_D=0, mw_valid=1. Latency is 1 cycle and there is no stall.
- IDLE, xm_valid=0: mw_valid<=0 and mw_IR<=0. The other mw_* fields hold.
- WAIT without mem_ack:
  - mem_req and its address/data/we stay stable.
  - mw_valid<=0; stall=1.
- WAIT with mem_ack:
  - stall=0 in this same cycle, so X/M advances at the edge.
  - Next edge: mem_req<=0, mw_IR=xm_IR, mw_O=xm_O, mw_valid=1.
  - mw_D=mem_rdata for lw, 0 for sw.
  - Next state IDLE.
  - No back-to-back issue: a following memory op issues on the cycle after return to IDLE.
- Address truncation: xm_O bits above ADDR_W are ignored.
- mem_ack while in IDLE is ignored.
- xm_* are held stable by stall during WAIT. Changes to xm_* in WAIT are not sampled until ack.

Optional Feature:
- Macro MEM_STAGE_TIMEOUT_EN.
- Defined:
  - A counter runs in WAIT.
  - If TIMEOUT_CYCLES cycles elapse without mem_ack, the stage aborts: mem_req<=0, mem_err<=1 (sticky), mw_valid=1 with mw_D=0, state IDLE.
  - stall=0 in the abort cycle.
- Undefined: no counter; WAIT persists indefinitely; mem_err is tied 0.

Decomposition:
- Shared package (proc_pkg): opcode constants (OP_LW, OP_SW, others), IR field positions (opcode [31:27], rd [26:22], rs [21:17], imm [16:0]), FSM state encoding (IDLE/WAIT).
- One natural sub-module, mw_out_reg: the M/W-side output register bank with load, bubble and clear controls.

Test Plan:
- Reset low mid-WAIT (mem_req=1) -> mem_req=0 and mw_valid=0 immediately without a clock edge; a later mem_ack is ignored.
- xm_IR=0x00C22000 (add), xm_O=34, xm_valid=1 -> next edge: mw_IR=0x00C22000, mw_O=34, mw_D=0, mw_valid=1; stall=0 throughout.
- lw, xm_IR=0x40C20004, xm_O=100, ack after 3 cycles with mem_rdata=0xDEADBEEF:
  - stall=1 for 4 cycles; mem_req=1, mem_we=0, mem_addr=100.
  - Edge after ack: mw_D=0xDEADBEEF, mw_valid=1, mem_req=0.
- sw, xm_IR=0x38C20004, xm_O=8, xm_B=-1, ack next cycle -> mem_we=1, mem_wdata=0xFFFFFFFF, mem_addr=8; mw_D=0; exactly 2 stall cycles.
- lw ack'd, then add in the next X/M slot -> add passes in 1 cycle with no stall, and mw_valid pattern is 0,…,1,1.
- With MEM_STAGE_TIMEOUT_EN, TIMEOUT_CYCLES=4, lw and no ack -> abort after 4 WAIT cycles: mem_err=1, mw_valid=1, mw_D=0, mem_req=0; mem_err stays 1 until reset.
